// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with
// valid/ready handshakes on both sides and a sideband tag per op.
// Optional feature macro: SHIFT_PIPE_CARRY_EN adds in_cin/out_cout and the
// ARM-style shifter carry that travels with each op.
// S1 holds the raw op; the shift is evaluated between S1 and S2, and S2 is
// the output register. Assumes WIDTH is a power of two and SHAMT_W >= log2(WIDTH).
module shift_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_sh,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic [TAG_W-1:0]   out_tag
`ifdef SHIFT_PIPE_CARRY_EN
    ,
    input  logic               in_cin,
    output logic               out_cout
`endif
);

    localparam int LW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_t;

    logic               s1_v;
    logic [WIDTH-1:0]   s1_a;
    logic [SHAMT_W-1:0] s1_shamt;
    sh_t                s1_sh;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_v;

    logic               s1_adv;
    logic               accept;

    logic [LW-1:0]      amt;
    logic [SHAMT_W-1:0] hi;
    logic               big;
    logic [WIDTH-1:0]   ror_y;
    logic [WIDTH-1:0]   y_next;

    // S1 may move into S2 whenever S2 is empty or being drained this cycle
    assign s1_adv    = !s2_v || out_ready;
    assign in_ready  = reset_n && !flush && (!s1_v || s1_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;

    // Shift datapath for the op held in S1; amounts >= WIDTH are saturated
    always_comb begin
        amt    = LW'(s1_shamt);
        hi     = s1_shamt >> LW;
        big    = |hi;
        ror_y  = '0;
        y_next = s1_a;
        for (int i = 0; i < WIDTH; i++) begin
            ror_y[i] = s1_a[LW'(i) + amt];
        end
        case (s1_sh)
            SH_LSL:  y_next = big ? '0 : (s1_a << amt);
            SH_LSR:  y_next = big ? '0 : (s1_a >> amt);
            SH_ASR:  y_next = big ? {WIDTH{s1_a[WIDTH-1]}}
                                  : $unsigned($signed(s1_a) >>> amt);
            default: y_next = ror_y;
        endcase
    end

`ifdef SHIFT_PIPE_CARRY_EN
    logic          s1_cin;
    logic          c_next;
    logic          amt_is_w;
    logic [LW-1:0] lsl_idx;
    logic [LW-1:0] lsr_idx;

    // Carry is the last bit shifted out; amount exactly WIDTH needs its own case
    always_comb begin
        amt_is_w = (hi == SHAMT_W'(1)) && (amt == '0);
        lsl_idx  = '0 - amt;
        lsr_idx  = amt - 1'b1;
        c_next   = s1_cin;
        if (s1_shamt != '0) begin
            case (s1_sh)
                SH_LSL:  c_next = amt_is_w ? s1_a[0]       : (big ? 1'b0 : s1_a[lsl_idx]);
                SH_LSR:  c_next = amt_is_w ? s1_a[WIDTH-1] : (big ? 1'b0 : s1_a[lsr_idx]);
                SH_ASR:  c_next = big ? s1_a[WIDTH-1] : s1_a[lsr_idx];
                default: c_next = y_next[WIDTH-1];
            endcase
        end
    end

    // Carry sideband registers follow the same load/hold rules as the data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_cin   <= 1'b0;
            out_cout <= 1'b0;
        end else if (!flush) begin
            if (s1_adv && s1_v) out_cout <= c_next;
            if (accept)         s1_cin   <= in_cin;
        end
    end
`endif

    // Pipeline valids and payloads; reset beats flush, flush drops both stages
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v     <= 1'b0;
            s1_a     <= '0;
            s1_shamt <= '0;
            s1_sh    <= SH_LSL;
            s1_tag   <= '0;
            s2_v     <= 1'b0;
            out_y    <= '0;
            out_tag  <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_y   <= y_next;
                    out_tag <= s1_tag;
                end
            end
            if (accept) begin
                s1_v     <= 1'b1;
                s1_a     <= in_a;
                s1_shamt <= in_shamt;
                s1_sh    <= sh_t'(in_sh);
                s1_tag   <= in_tag;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed test of shift_pipe (WIDTH=32). Carry checks are
// compiled in when SHIFT_PIPE_CARRY_EN is defined.
module tb_shift_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [7:0]  in_shamt;
    logic [1:0]  in_sh;
    logic [3:0]  in_tag;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic        out_cout;

    int checks = 0;
    int errors = 0;

    shift_pipe #(.WIDTH(32), .SHAMT_W(8), .TAG_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_sh     (in_sh),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
`ifdef SHIFT_PIPE_CARRY_EN
        ,
        .in_cin    (in_cin),
        .out_cout  (out_cout)
`endif
    );

`ifndef SHIFT_PIPE_CARRY_EN
    assign out_cout = 1'b0;
`endif

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] stream_a(input int k);
        return 32'(k) * 32'h0101_0000 + 32'h0000_0011;
    endfunction

    // One isolated op: accept, no result after one edge, result after two, gone after three
    task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [7:0] n,
                                  input logic [1:0] sh, input logic [3:0] tag, input logic cin,
                                  input logic [31:0] exp_y, input logic exp_c);
        in_a     = a;
        in_shamt = n;
        in_sh    = sh;
        in_tag   = tag;
        in_cin   = cin;
        in_valid = 1'b1;
        #1;
        check_output({name, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_output({name, "_valid_early"}, 32'(out_valid), 32'd0);
        step();
        check_output({name, "_valid"}, 32'(out_valid), 32'd1);
        check_output({name, "_y"}, out_y, exp_y);
        check_output({name, "_tag"}, 32'(out_tag), 32'(tag));
`ifdef SHIFT_PIPE_CARRY_EN
        check_output({name, "_cout"}, 32'(out_cout), 32'(exp_c));
`else
        if (exp_c === 1'bx) $display("[TB] unreachable");
`endif
        step();
        check_output({name, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  k;
        int  e;
        bit  saw_block;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_shamt  = '0;
        in_sh     = '0;
        in_tag    = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;

        step();
        step();
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_y", out_y, 32'd0);
        check_output("rst_out_tag", 32'(out_tag), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef SHIFT_PIPE_CARRY_EN
        check_output("rst_out_cout", 32'(out_cout), 32'd0);
`endif
        reset_n = 1'b1;
        step();
        check_output("post_rst_in_ready", 32'(in_ready), 32'd1);

        apply_stimulus("lsl1",     32'h8000_0001, 8'd1,   2'b00, 4'h1, 1'b0, 32'h0000_0002, 1'b1);
        apply_stimulus("lsr32",    32'h8000_0000, 8'd32,  2'b01, 4'h2, 1'b0, 32'h0000_0000, 1'b1);
        apply_stimulus("asr40",    32'h8000_0000, 8'd40,  2'b10, 4'h3, 1'b0, 32'hFFFF_FFFF, 1'b1);
        apply_stimulus("ror4",     32'h0000_00F1, 8'd4,   2'b11, 4'h4, 1'b0, 32'h1000_000F, 1'b0);
        apply_stimulus("ror36",    32'h0000_00F1, 8'd36,  2'b11, 4'h5, 1'b0, 32'h1000_000F, 1'b0);
        apply_stimulus("ror0",     32'h0000_00F1, 8'd0,   2'b11, 4'h6, 1'b1, 32'h0000_00F1, 1'b1);
        apply_stimulus("lsl32",    32'h0000_0001, 8'd32,  2'b00, 4'h7, 1'b0, 32'h0000_0000, 1'b1);
        apply_stimulus("lsl33",    32'h0000_0001, 8'd33,  2'b00, 4'h8, 1'b1, 32'h0000_0000, 1'b0);
        apply_stimulus("asr5",     32'h8000_0010, 8'd5,   2'b10, 4'h9, 1'b0, 32'hFC00_0000, 1'b1);
        apply_stimulus("lsr255",   32'h0000_0100, 8'd255, 2'b01, 4'hA, 1'b0, 32'h0000_0000, 1'b0);
        apply_stimulus("asr32",    32'h8000_0000, 8'd32,  2'b10, 4'hB, 1'b0, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back stream of 8 ops with a 3-cycle downstream stall
        k = 0;
        e = 0;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 40 && e < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (k < 8) begin
                in_valid = 1'b1;
                in_a     = stream_a(k);
                in_shamt = 8'd4;
                in_sh    = 2'b00;
                in_tag   = k[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && !out_ready) begin
                check_output("stall_tag", 32'(out_tag), 32'(e));
                check_output("stall_y", out_y, stream_a(e) << 4);
            end
            if (out_valid && out_ready) begin
                check_output("stream_y", out_y, stream_a(e) << 4);
                check_output("stream_tag", 32'(out_tag), 32'(e));
                e++;
            end
            if (in_valid && in_ready) k++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output("stream_count", 32'(e), 32'd8);
        check_output("stream_in_ready_dropped", 32'(saw_block), 32'd1);
        step();
        check_output("stream_drained", 32'(out_valid), 32'd0);

        // Flush with two ops in flight and a third offered in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0003;
        in_shamt  = 8'd1;
        in_sh     = 2'b00;
        in_tag    = 4'h1;
        step();
        in_tag = 4'h2;
        #1;
        check_output("flush_setup_ready", 32'(in_ready), 32'd1);
        step();
        check_output("flush_setup_valid", 32'(out_valid), 32'd1);
        flush  = 1'b1;
        in_tag = 4'h3;
        #1;
        check_output("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_output("flush_valid0", 32'(out_valid), 32'd0);
        step();
        check_output("flush_valid1", 32'(out_valid), 32'd0);
        step();
        check_output("flush_valid2", 32'(out_valid), 32'd0);
        apply_stimulus("post_flush", 32'h0000_00F0, 8'd4, 2'b01, 4'hC, 1'b0, 32'h0000_000F, 1'b0);

        // Reset pulse with two ops in flight
        in_valid = 1'b1;
        in_a     = 32'h1234_5678;
        in_shamt = 8'd0;
        in_sh    = 2'b00;
        in_tag   = 4'h5;
        step();
        in_tag = 4'h6;
        step();
        reset_n = 1'b0;
        in_tag  = 4'h7;
        step();
        check_output("midrst_valid", 32'(out_valid), 32'd0);
        check_output("midrst_y", out_y, 32'd0);
        check_output("midrst_tag", 32'(out_tag), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("midrst_ready_after", 32'(in_ready), 32'd1);
        step();
        check_output("midrst_stale0", 32'(out_valid), 32'd0);
        step();
        check_output("midrst_stale1", 32'(out_valid), 32'd0);
        apply_stimulus("post_rst", 32'h0000_0001, 8'd1, 2'b11, 4'hD, 1'b0, 32'h8000_0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
